// File: rtl/instruction_fetcher_if.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetcher_if
//  Purpose  : Groups the instruction-cache read handshake, the redirect
//             strobe and the decode hand-off of the instruction fetcher.
//             master = fetcher view, slave = cache/decode/branch view.
//  Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetcher_if;
    logic        fetch_enable;
    logic        read_enable;
    logic [63:0] address;
    logic [2:0]  data_size;
    logic        send_enable;
    logic [63:0] data;
    logic        send_complete;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        decode_ready;

    modport master (
        input  fetch_enable,
        output read_enable,
        output address,
        output data_size,
        input  send_enable,
        input  data,
        output send_complete,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        output instr,
        output instr_pc,
        input  decode_ready
    );

    modport slave (
        output fetch_enable,
        input  read_enable,
        input  address,
        input  data_size,
        output send_enable,
        output data,
        input  send_complete,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output decode_ready
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetcher.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetcher
//  Purpose  : Single-outstanding instruction fetch engine. Requests one 4-byte
//             instruction from the cache, acknowledges it, holds it for decode
//             and advances the PC (or follows a redirect). A redirect arriving
//             while a cache transaction is in flight lets the transaction
//             finish, drops its instruction and restarts at the latest target.
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_fetcher #(
    parameter logic [63:0] ENTRY_PC = 64'h0
) (
    input  wire logic              clock,
    input  wire logic              reset,
    instruction_fetcher_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_RELEASE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic        r_kill;
    logic [63:0] r_target;
    logic        r_read_enable;
    logic [63:0] r_address;
    logic        r_send_complete;
    logic        r_instr_valid;
    logic [31:0] r_instr;
    logic [63:0] r_instr_pc;

    logic [63:0] w_redirect_aligned;
    logic        w_kill;
    logic [63:0] w_target;
    logic [63:0] w_pc_inc;
    logic        w_unused_bits;

    // Redirect targets are forced to 4-byte alignment; a redirect seen in the
    // same cycle as the kill decision is folded in so the newest target wins.
    assign w_redirect_aligned = {bus.redirect_pc[63:2], 2'b00};
    assign w_kill             = r_kill | bus.redirect_valid;
    assign w_target           = bus.redirect_valid ? w_redirect_aligned : r_target;
    assign w_pc_inc           = r_pc + 64'd4;
    assign w_unused_bits      = ^{bus.data[63:32], bus.redirect_pc[1:0]};

    assign bus.read_enable   = r_read_enable;
    assign bus.address       = r_address;
    assign bus.data_size     = 3'd2;
    assign bus.send_complete = r_send_complete;
    assign bus.instr_valid   = r_instr_valid;
    assign bus.instr         = r_instr;
    assign bus.instr_pc      = r_instr_pc;

    // Fetch FSM: all handshake outputs are produced as registers alongside
    // the state so the cache and decode see glitch-free signals.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_pc            <= ENTRY_PC;
            r_kill          <= 1'b0;
            r_target        <= 64'd0;
            r_read_enable   <= 1'b0;
            r_address       <= 64'd0;
            r_send_complete <= 1'b0;
            r_instr_valid   <= 1'b0;
            r_instr         <= 32'd0;
            r_instr_pc      <= 64'd0;
        end else begin
            r_send_complete <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.redirect_valid) begin
                        r_pc <= w_redirect_aligned;
                    end
                    if (bus.fetch_enable) begin
                        r_state       <= ST_REQUEST;
                        r_read_enable <= 1'b1;
                        r_address     <= bus.redirect_valid ? w_redirect_aligned : r_pc;
                    end
                end

                ST_REQUEST: begin
                    if (bus.redirect_valid) begin
                        r_kill   <= 1'b1;
                        r_target <= w_redirect_aligned;
                    end
                    if (bus.send_enable) begin
                        r_read_enable   <= 1'b0;
                        r_send_complete <= 1'b1;
                        r_state         <= ST_RELEASE;
                        // A killed fetch is still acknowledged but never captured
                        if (!w_kill) begin
                            r_instr    <= bus.data[31:0];
                            r_instr_pc <= r_pc;
                        end
                    end
                end

                ST_RELEASE: begin
                    if (bus.redirect_valid) begin
                        r_kill   <= 1'b1;
                        r_target <= w_redirect_aligned;
                    end
                    if (!bus.send_enable) begin
                        if (w_kill) begin
                            r_kill        <= 1'b0;
                            r_pc          <= w_target;
                            r_address     <= w_target;
                            r_read_enable <= 1'b1;
                            r_state       <= ST_REQUEST;
                        end else begin
                            r_instr_valid <= 1'b1;
                            r_state       <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    // Redirect outranks decode_ready; the held instr is dropped
                    if (bus.redirect_valid) begin
                        r_pc          <= w_redirect_aligned;
                        r_address     <= w_redirect_aligned;
                        r_instr_valid <= 1'b0;
                        r_read_enable <= 1'b1;
                        r_state       <= ST_REQUEST;
                    end else if (bus.decode_ready) begin
                        r_pc          <= w_pc_inc;
                        r_instr_valid <= 1'b0;
                        if (bus.fetch_enable) begin
                            r_address     <= w_pc_inc;
                            r_read_enable <= 1'b1;
                            r_state       <= ST_REQUEST;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetcher.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_instruction_fetcher
//  Purpose  : Self-checking bench for instruction_fetcher. A transaction-level
//             model predicts the fetch address stream, acknowledges and the
//             instruction handed to decode; a reactive cache model answers
//             requests with variable latency and hold time.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetcher;

    localparam logic [63:0] ENTRY = 64'h1000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instruction_fetcher_if bus_if();

    instruction_fetcher #(.ENTRY_PC(ENTRY)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    // stimulus requested for the next clock edge
    bit          t_rst_n, t_fe, t_rv, t_dr, spur_en;
    logic [63:0] t_rpc;
    int          cfg_lat, cfg_hold;
    logic [31:0] cfg_data;

    // cache responder state
    int c_state, c_cnt;
    bit c_spur;

    // model: expected fetch address, request/ack/hold expectations
    logic [63:0] m_addr, m_ipc, m_tgt;
    logic [31:0] m_instr;
    bit          m_req, m_open, m_sc, m_valid, m_kill;

    int cnt_sc, cnt_valid, cnt_re;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_addr  = ENTRY;
        m_ipc   = 64'd0;
        m_tgt   = 64'd0;
        m_instr = 32'd0;
        m_req   = 1'b0;
        m_open  = 1'b0;
        m_sc    = 1'b0;
        m_valid = 1'b0;
        m_kill  = 1'b0;
        c_state = 0;
        c_cnt   = 0;
        c_spur  = 1'b0;
    endfunction

    // One clock: compare outputs, drive inputs for the next edge, advance model
    task automatic tick();
        logic [63:0] tgt;
        logic        se;
        @(posedge clk);
        #1;
        if (rst_n) begin
            chk("read_enable", 64'(bus_if.read_enable), 64'(m_req));
            if (m_req) chk("address", bus_if.address, m_addr);
            chk("send_complete", 64'(bus_if.send_complete), 64'(m_sc));
            chk("instr_valid", 64'(bus_if.instr_valid), 64'(m_valid));
            if (m_valid) begin
                chk("instr", 64'(bus_if.instr), 64'(m_instr));
                chk("instr_pc", bus_if.instr_pc, m_ipc);
            end
            chk("data_size", 64'(bus_if.data_size), 64'd2);
            if (bus_if.send_complete) cnt_sc++;
            if (bus_if.instr_valid)   cnt_valid++;
            if (bus_if.read_enable)   cnt_re++;
        end
        rst_n                 = t_rst_n;
        bus_if.fetch_enable   = t_fe;
        bus_if.redirect_valid = t_rv;
        bus_if.redirect_pc    = t_rpc;
        bus_if.decode_ready   = t_dr;
        if (!rst_n) begin
            bus_if.send_enable = 1'b0;
            model_reset();
        end else begin
            // cache responder
            if (c_spur) begin
                bus_if.send_enable = 1'b0;
                c_spur = 1'b0;
            end
            case (c_state)
                0: begin
                    if (bus_if.read_enable) begin
                        c_cnt = cfg_lat;
                        if (c_cnt == 0) begin
                            bus_if.send_enable = 1'b1;
                            bus_if.data        = {$urandom(), cfg_data};
                            c_state = 2;
                        end else c_state = 1;
                    end else if (spur_en && !m_req && !m_open && $urandom_range(0, 5) == 0) begin
                        bus_if.send_enable = 1'b1;
                        bus_if.data        = {$urandom(), $urandom()};
                        c_spur = 1'b1;
                    end
                end
                1: begin
                    c_cnt--;
                    if (c_cnt == 0) begin
                        bus_if.send_enable = 1'b1;
                        bus_if.data        = {$urandom(), cfg_data};
                        c_state = 2;
                    end
                end
                2: begin
                    if (bus_if.send_complete) begin
                        c_cnt = cfg_hold;
                        if (c_cnt == 0) begin
                            bus_if.send_enable = 1'b0;
                            c_state = 0;
                        end else c_state = 3;
                    end
                end
                default: begin
                    c_cnt--;
                    if (c_cnt == 0) begin
                        bus_if.send_enable = 1'b0;
                        c_state = 0;
                    end
                end
            endcase

            // model: what the next edge does to the fetch transaction
            se   = bus_if.send_enable;
            tgt  = {t_rpc[63:2], 2'b00};
            m_sc = 1'b0;
            if (m_req) begin
                if (t_rv) begin m_kill = 1'b1; m_tgt = tgt; end
                if (se) begin
                    m_req  = 1'b0;
                    m_open = 1'b1;
                    m_sc   = 1'b1;
                    if (!m_kill) begin
                        m_instr = bus_if.data[31:0];
                        m_ipc   = m_addr;
                    end
                end
            end else if (m_open) begin
                if (t_rv) begin m_kill = 1'b1; m_tgt = tgt; end
                if (!se) begin
                    m_open = 1'b0;
                    if (m_kill) begin
                        m_addr = m_tgt;
                        m_kill = 1'b0;
                        m_req  = 1'b1;
                    end else m_valid = 1'b1;
                end
            end else if (m_valid) begin
                if (t_rv) begin
                    m_addr = tgt; m_valid = 1'b0; m_req = 1'b1;
                end else if (t_dr) begin
                    m_addr = m_ipc + 64'd4; m_valid = 1'b0; m_req = t_fe;
                end
            end else begin
                if (t_rv) m_addr = tgt;
                m_req = t_fe;
            end
        end
    endtask

    // sel 0 = read_enable, 1 = instr_valid; bounded wait for a level
    task automatic wait_sig(input int sel, input logic val, input string name);
        int n = 0;
        while ((((sel == 0) ? bus_if.read_enable : bus_if.instr_valid) !== val) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_%s: got timeout after 60 cycles expected level %0d", name, val);
        end
    endtask

    initial begin
        rst_n = 1'b0; t_rst_n = 1'b0;
        t_fe = 1'b0; t_rv = 1'b0; t_dr = 1'b0; t_rpc = 64'd0; spur_en = 1'b0;
        cfg_lat = 3; cfg_hold = 0; cfg_data = 32'h00500093;
        bus_if.fetch_enable = 1'b0; bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc = 64'd0; bus_if.decode_ready = 1'b0;
        bus_if.send_enable = 1'b0; bus_if.data = 64'd0;
        cnt_sc = 0; cnt_valid = 0; cnt_re = 0;
        model_reset();
        repeat (3) tick();
        chk("reset_instr_valid", 64'(bus_if.instr_valid), 64'd0);
        chk("reset_address", bus_if.address, 64'd0);

        // first fetch after reset, cache answers after 3 cycles
        t_fe = 1'b1; t_rst_n = 1'b1; cnt_sc = 0;
        wait_sig(0, 1'b1, "first_req");
        chk("first_address", bus_if.address, 64'h1000);
        wait_sig(1, 1'b1, "first_valid");
        chk("first_ack_pulses", 64'(cnt_sc), 64'd1);
        chk("first_instr", 64'(bus_if.instr), 64'h00500093);
        chk("first_instr_pc", bus_if.instr_pc, 64'h1000);

        // decode stalls 5 cycles: stable, no new request
        cnt_re = 0;
        repeat (5) tick();
        chk("stall_no_request", 64'(cnt_re), 64'd0);
        chk("stall_instr", 64'(bus_if.instr), 64'h00500093);
        chk("stall_valid", 64'(bus_if.instr_valid), 64'd1);
        t_dr = 1'b1; tick(); t_dr = 1'b0;
        wait_sig(0, 1'b1, "seq_req");
        chk("seq_address", bus_if.address, 64'h1004);

        // redirect during REQUEST: completes, dropped, restart at aligned target
        t_rv = 1'b1; t_rpc = 64'h2002; tick(); t_rv = 1'b0;
        cnt_valid = 0;
        wait_sig(0, 1'b0, "kill_drop");
        wait_sig(0, 1'b1, "kill_req");
        chk("kill_address", bus_if.address, 64'h2000);
        chk("kill_no_valid", 64'(cnt_valid), 64'd0);

        // redirect and decode_ready together in HOLD: redirect wins
        cfg_data = 32'h12345678;
        wait_sig(1, 1'b1, "hold_valid");
        t_rv = 1'b1; t_rpc = 64'h3000; t_dr = 1'b1; tick(); t_rv = 1'b0; t_dr = 1'b0;
        wait_sig(0, 1'b1, "prio_req");
        chk("prio_address", bus_if.address, 64'h3000);

        // PC wrap at the top of the address space
        wait_sig(1, 1'b1, "wrap_hold");
        t_rv = 1'b1; t_rpc = 64'hFFFF_FFFF_FFFF_FFFF; tick(); t_rv = 1'b0;
        wait_sig(0, 1'b1, "wrap_req");
        chk("wrap_top_address", bus_if.address, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_sig(1, 1'b1, "wrap_valid");
        chk("wrap_instr_pc", bus_if.instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cfg_lat = 0;
        t_dr = 1'b1; tick(); t_dr = 1'b0;
        wait_sig(0, 1'b1, "wrap_next");
        chk("wrap_address", bus_if.address, 64'h0);

        // reset while the cache is presenting data in REQUEST
        rst_n = 1'b0; t_rst_n = 1'b0;
        #1;
        chk("rst_read_enable", 64'(bus_if.read_enable), 64'd0);
        chk("rst_address", bus_if.address, 64'd0);
        chk("rst_send_complete", 64'(bus_if.send_complete), 64'd0);
        chk("rst_instr_valid", 64'(bus_if.instr_valid), 64'd0);
        chk("rst_instr", 64'(bus_if.instr), 64'd0);
        chk("rst_instr_pc", bus_if.instr_pc, 64'd0);
        cnt_sc = 0;
        repeat (3) tick();
        cfg_lat = 1; t_rst_n = 1'b1;
        wait_sig(0, 1'b1, "post_rst_req");
        chk("post_rst_address", bus_if.address, ENTRY);
        chk("post_rst_no_ack", 64'(cnt_sc), 64'd0);

        // randomized traffic against the model
        spur_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            t_fe     = ($urandom_range(0, 7) != 0);
            t_rv     = ($urandom_range(0, 11) == 0);
            t_rpc    = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFE
                                                    : {$urandom(), $urandom()};
            t_dr     = ($urandom_range(0, 1) == 1);
            cfg_lat  = $urandom_range(0, 3);
            cfg_hold = $urandom_range(0, 2);
            cfg_data = $urandom();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
